// File: rtl/seq_detect_pkg.sv
// Shared types for the 1010 serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S10,
    S101,
    S1010
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_detect_1010.sv
// Moore FSM flagging every (overlapping) occurrence of 1-0-1-0 on a serial input.
// State names record the longest matched prefix of the pattern.
module seq_detect_1010
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // S1010 on a 1 falls back to S101 so the trailing "10" starts the next match.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = din ? S1   : IDLE;
      S1:      state_next = din ? S1   : S10;
      S10:     state_next = din ? S101 : IDLE;
      S101:    state_next = din ? S1   : S1010;
      S1010:   state_next = din ? S101 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dout = (state == S1010);
  end

endmodule

// File: tb/tb_seq_detect_1010.sv
// Directed bench for seq_detect_1010: a shift-register model predicts dout, the
// expected state walk comes from the test plan, both queued and checked after each edge.
module tb_seq_detect_1010;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic din = 1'b0;
  logic dout;

  seq_detect_1010 dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   exp_dout;
    state_t exp_state;
    string  tag;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] hist = 4'b0000;
  int         nvalid = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed dout=%b expected dout=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t obs, input state_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed state=%s(%0d) expected state=%s", tag, obs.name(), obs,
             exp.name());
    end
  endtask

  // Drive one bit, queue the prediction, check it one step after the sampling edge.
  task automatic step(input logic b, input state_t es, input string tag);
    exp_t e;
    din  = b;
    hist = {hist[2:0], b};
    if (nvalid < 4) nvalid++;
    e.exp_dout  = (nvalid >= 4) && (hist == PATTERN);
    e.exp_state = es;
    e.tag       = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    $display("t=%0t din=%b dout=%b state=%s state_next=%s", $time, din, dout,
             dut.state.name(), dut.state_next.name());
    e = sb.pop_front();
    check_bit({e.tag, "_dout"}, dout, e.exp_dout);
    check_state({e.tag, "_state"}, dut.state, e.exp_state);
  endtask

  // Assert reset off-edge, check it takes effect with no clock, hold, release off-edge.
  task automatic do_reset(input int cycles, input string tag);
    resetn = 1'b0;
    din    = 1'b1;
    #1;
    check_bit({tag, "_async_dout"}, dout, 1'b0);
    check_state({tag, "_async_state"}, dut.state, IDLE);
    repeat (cycles) @(posedge clk);
    #1;
    check_bit({tag, "_held_dout"}, dout, 1'b0);
    check_state({tag, "_held_state"}, dut.state, IDLE);
    resetn = 1'b1;
    hist   = 4'b0000;
    nvalid = 0;
  endtask

  initial begin
    // Reset, then zeros must not trigger.
    @(posedge clk);
    #1;
    do_reset(2, "rst");
    step(1'b0, IDLE, "zero1");
    step(1'b0, IDLE, "zero2");
    step(1'b0, IDLE, "zero3");

    // Basic match.
    do_reset(1, "rst_basic");
    step(1'b1, S1,    "basic1");
    step(1'b0, S10,   "basic2");
    step(1'b1, S101,  "basic3");
    step(1'b0, S1010, "basic4");

    // Overlap and restart.
    do_reset(1, "rst_ovl");
    step(1'b1, S1,    "ovl1");
    step(1'b0, S10,   "ovl2");
    step(1'b1, S101,  "ovl3");
    step(1'b0, S1010, "ovl4");
    step(1'b1, S101,  "ovl5");
    step(1'b1, S1,    "ovl6");
    step(1'b0, S10,   "ovl7");
    step(1'b1, S101,  "ovl8");
    step(1'b0, S1010, "ovl9");

    // Back-to-back overlap.
    do_reset(1, "rst_b2b");
    step(1'b1, S1,    "b2b1");
    step(1'b0, S10,   "b2b2");
    step(1'b1, S101,  "b2b3");
    step(1'b0, S1010, "b2b4");
    step(1'b1, S101,  "b2b5");
    step(1'b0, S1010, "b2b6");

    // Reset in the middle of a partial match.
    do_reset(1, "rst_mid0");
    step(1'b1, S1,   "mid1");
    step(1'b0, S10,  "mid2");
    step(1'b1, S101, "mid3");
    do_reset(1, "rst_mid");
    step(1'b0, IDLE,  "mid4");
    step(1'b1, S1,    "mid5");
    step(1'b0, S10,   "mid6");
    step(1'b1, S101,  "mid7");
    step(1'b0, S1010, "mid8");

    // Near misses.
    do_reset(1, "rst_nm");
    step(1'b1, S1,   "nm1");
    step(1'b1, S1,   "nm2");
    step(1'b0, S10,  "nm3");
    step(1'b0, IDLE, "nm4");
    step(1'b1, S1,   "nm5");
    step(1'b0, S10,  "nm6");
    step(1'b0, IDLE, "nm7");
    step(1'b1, S1,   "nm8");
    step(1'b0, S10,  "nm9");
    step(1'b1, S101, "nm10");
    step(1'b1, S1,   "nm11");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
